// File: rtl/imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe
//
// Pipelined immediate generator for the decode->execute boundary. Each
// accepted instruction has its XLEN-wide immediate built combinationally from
// the instruction bits and the format select. The result is captured together
// with a sideband tag. One cycle after acceptance it is presented downstream.
//
// Two entries of storage form a skid buffer:
//   M : main output register, drives o_imm/o_tag/o_illegal/o_valid
//   K : skid register, catches the one extra transfer that can arrive after
//       M stalls, because o_ready is registered and reacts one cycle late
//
// Ports
//   i_clk      clock, all state changes on the rising edge
//   i_rst      synchronous active-high reset (dominates flush)
//   i_flush    synchronous flush of both entries, drops a same-cycle accept
//   i_valid    upstream offers an instruction
//   o_ready    registered, high while the skid register is empty
//   i_inst     instruction bits [31:7], indexed by ISA bit number
//   i_imm_sel  000 I, 001 S, 010 B, 011 J, 100 U, 101 Z, 110 SHAMT, 111 rsvd
//   i_tag      sideband (typically PC), carried unmodified
//   o_valid    output entry valid
//   i_ready    downstream accepts the output entry
//   o_imm      extended immediate (0 when o_valid is low)
//   o_tag      sideband of the output entry (0 when o_valid is low)
//   o_illegal  output entry came from the reserved select
//
// Parameters
//   XLEN   32 or 64, width of the produced immediate
//   TAG_W  width of the sideband
// ---------------------------------------------------------------------------
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:7]      i_inst,
    input  logic [2:0]       i_imm_sel,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [XLEN-1:0]  o_imm,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_illegal
);

    // Only the two RISC-V base widths are meaningful for this block. Any
    // other value stops elaboration instead of building a broken datapath.
    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_gen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    typedef enum logic [2:0] {
        SEL_I     = 3'b000,
        SEL_S     = 3'b001,
        SEL_B     = 3'b010,
        SEL_J     = 3'b011,
        SEL_U     = 3'b100,
        SEL_Z     = 3'b101,
        SEL_SHAMT = 3'b110,
        SEL_RSV   = 3'b111
    } imm_sel_e;

    // An entry whose valid bit is low always has all other fields at zero.
    // The outputs can therefore be driven straight from M without extra
    // gating and still read as zero when nothing is valid.
    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             illegal;
        logic             valid;
    } entry_t;

    logic [XLEN-1:0] sign_fill;
    logic [XLEN-1:0] new_imm;
    logic            new_illegal;
    entry_t          incoming;

    entry_t          m_q;
    entry_t          m_next;
    entry_t          k_q;
    entry_t          k_next;
    logic            ready_q;
    logic            ready_next;

    logic            accept;
    logic            emit;

    // Immediate formation. Every format starts from a zero immediate and a
    // clear illegal flag. The reserved select leaves the immediate at zero
    // and raises the flag, so it can never produce X. For U, the low 32 bits
    // are written over a full sign fill. At XLEN=32 this gives the plain LUI
    // value, and at XLEN=64 it gives the RV64 sign-extended LUI/AUIPC value.
    // SHAMT picks up bit 25 only when the shift range is six bits wide.
    always_comb begin
        sign_fill   = {XLEN{i_inst[31]}};
        new_imm     = '0;
        new_illegal = 1'b0;
        case (imm_sel_e'(i_imm_sel))
            SEL_I: begin
                new_imm = {sign_fill[XLEN-1:12], i_inst[31:20]};
            end
            SEL_S: begin
                new_imm = {sign_fill[XLEN-1:12], i_inst[31:25], i_inst[11:7]};
            end
            SEL_B: begin
                new_imm = {sign_fill[XLEN-1:12], i_inst[7], i_inst[30:25],
                           i_inst[11:8], 1'b0};
            end
            SEL_J: begin
                new_imm = {sign_fill[XLEN-1:20], i_inst[19:12], i_inst[20],
                           i_inst[30:21], 1'b0};
            end
            SEL_U: begin
                new_imm        = sign_fill;
                new_imm[31:0]  = {i_inst[31:12], 12'b0};
            end
            SEL_Z: begin
                new_imm[4:0]   = i_inst[19:15];
            end
            SEL_SHAMT: begin
                new_imm[4:0]   = i_inst[24:20];
                if (XLEN == 64) begin
                    new_imm[5] = i_inst[25];
                end
            end
            default: begin
                new_illegal    = 1'b1;
            end
        endcase
    end

    // Package the freshly formed immediate with its sideband. It becomes
    // either the new M or the new K, depending on the occupancy below.
    always_comb begin
        incoming.imm     = new_imm;
        incoming.tag     = i_tag;
        incoming.illegal = new_illegal;
        incoming.valid   = 1'b1;
    end

    // Skid buffer next-state logic. The cases are tested in priority order.
    //  - flush empties everything and drops any same-cycle request.
    //  - when M leaves while K is holding data, K slides into M. Upstream was
    //    already stalled, so no accept can collide with this move.
    //  - an accept goes to M when M is empty or is leaving this cycle.
    //    Accept and emit together simply replace M, so no bubble appears.
    //  - an accept while M is stalled lands in K, and ready drops.
    //  - an emit with nothing behind it leaves M empty.
    // Ready always tracks "K will be empty". Because it is a register, it
    // never has a combinational path from i_valid or i_ready.
    always_comb begin
        m_next     = m_q;
        k_next     = k_q;
        ready_next = ready_q;
        accept     = i_valid & ready_q;
        emit       = m_q.valid & i_ready;
        if (i_flush) begin
            m_next     = '0;
            k_next     = '0;
            ready_next = 1'b1;
        end else if (emit && k_q.valid) begin
            m_next     = k_q;
            k_next     = '0;
            ready_next = 1'b1;
        end else if (accept && (!m_q.valid || emit)) begin
            m_next     = incoming;
        end else if (accept) begin
            k_next     = incoming;
            ready_next = 1'b0;
        end else if (emit) begin
            m_next     = '0;
        end
    end

    // State registers. Reset wins over everything: both entries are
    // discarded, all output fields return to zero, and the block reports
    // ready again.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            m_q     <= '0;
            k_q     <= '0;
            ready_q <= 1'b1;
        end else begin
            m_q     <= m_next;
            k_q     <= k_next;
            ready_q <= ready_next;
        end
    end

    // Outputs come directly from registers. Because an invalid entry holds
    // only zeros, the data outputs read zero whenever o_valid is low.
    always_comb begin
        o_ready   = ready_q;
        o_valid   = m_q.valid;
        o_imm     = m_q.imm;
        o_tag     = m_q.tag;
        o_illegal = m_q.illegal;
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// tb_imm_gen_pipe
//
// Drives one XLEN=32 and one XLEN=64 instance of imm_gen_pipe from the same
// stimulus. The reference model treats the block as a two-deep FIFO. It is
// ready while fewer than two entries are held. Its head is what the output
// shows. Expected immediates are built from the instruction-format rules
// with signed arithmetic.
// ---------------------------------------------------------------------------
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        valid = 1'b0;
    logic        irdy = 1'b0;
    logic [31:7] inst = '0;
    logic [2:0]  sel = '0;
    logic [31:0] tag = '0;

    logic        rdy32, ov32, ill32;
    logic [31:0] imm32, tag32;
    logic        rdy64, ov64, ill64;
    logic [63:0] imm64;
    logic [31:0] tag64;

    typedef struct {
        logic [31:0] e32;
        logic [63:0] e64;
        logic [31:0] tag;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid),
        .o_ready(rdy32), .i_inst(inst), .i_imm_sel(sel), .i_tag(tag),
        .o_valid(ov32), .i_ready(irdy), .o_imm(imm32), .o_tag(tag32),
        .o_illegal(ill32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid),
        .o_ready(rdy64), .i_inst(inst), .i_imm_sel(sel), .i_tag(tag),
        .o_valid(ov64), .i_ready(irdy), .o_imm(imm64), .o_tag(tag64),
        .o_illegal(ill64)
    );

    // Reference immediate for a 64-bit machine, computed from the format rules.
    function automatic logic [63:0] ref64(input logic [31:0] w, input logic [2:0] s);
        logic signed [11:0] i12;
        logic signed [12:0] b13;
        logic signed [20:0] j21;
        logic signed [31:0] u32;
        longint             r;
        r = 0;
        case (s)
            3'd0: begin i12 = w[31:20]; r = longint'(i12); end
            3'd1: begin i12 = {w[31:25], w[11:7]}; r = longint'(i12); end
            3'd2: begin b13 = {w[31], w[7], w[30:25], w[11:8], 1'b0}; r = longint'(b13); end
            3'd3: begin j21 = {w[31], w[19:12], w[20], w[30:21], 1'b0}; r = longint'(j21); end
            3'd4: begin u32 = {w[31:12], 12'b0}; r = longint'(u32); end
            3'd5: r = longint'({59'b0, w[19:15]});
            3'd6: r = longint'({58'b0, w[25:20]});
            default: r = 0;
        endcase
        return r;
    endfunction

    // Reference for a 32-bit machine: the same value truncated, except that
    // the shift amount is five bits wide.
    function automatic logic [31:0] ref32(input logic [31:0] w, input logic [2:0] s);
        logic [63:0] full;
        full = ref64(w, s);
        if (s == 3'd6) return {27'b0, w[24:20]};
        return full[31:0];
    endfunction

    // One clock of stimulus plus the FIFO-level model update. Inputs are held
    // until the next call. On return we are 1 time unit past the edge, and
    // the model describes the state the DUT should now be in.
    task automatic tick(input logic v, input logic [2:0] s, input logic [31:0] w,
                        input logic [31:0] t, input logic r_in, input logic f,
                        input logic rs);
        logic acc, emi;
        exp_t e;
        valid = v; sel = s; inst = w[31:7]; tag = t; irdy = r_in; flush = f; rst = rs;
        acc   = v && (q.size() < 2) && !f && !rs;
        emi   = (q.size() > 0) && r_in;
        e.e32 = ref32(w, s);
        e.e64 = ref64(w, s);
        e.tag = t;
        e.ill = (s == 3'b111);
        @(posedge clk);
        #1;
        if (rs || f) begin
            q.delete();
        end else begin
            if (emi) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
    endtask

    task automatic test_reset();
        tick(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 3'd0, 32'hFFFFFFFF, 32'hDEAD, 1'b0, 1'b0, 1'b1);
        checks++; if (ov32 !== 1'b0) begin errors++; $display("[TB] FAIL reset ov32: got %b expected 0", ov32); end
        checks++; if (ov64 !== 1'b0) begin errors++; $display("[TB] FAIL reset ov64: got %b expected 0", ov64); end
        checks++; if (rdy32 !== 1'b1 || rdy64 !== 1'b1) begin errors++; $display("[TB] FAIL reset ready: got %b/%b expected 1/1", rdy32, rdy64); end
        checks++; if (imm32 !== 32'h0 || imm64 !== 64'h0) begin errors++; $display("[TB] FAIL reset imm: got %h/%h expected 0", imm32, imm64); end
        checks++; if (tag32 !== 32'h0 || tag64 !== 32'h0 || ill32 !== 1'b0 || ill64 !== 1'b0) begin errors++; $display("[TB] FAIL reset tag/ill: got %h/%h %b/%b expected 0", tag32, tag64, ill32, ill64); end
        tick(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_formats32();
        logic [31:0] ws  [6];
        logic [2:0]  ss  [6];
        logic [31:0] e32 [6];
        logic [63:0] e64 [6];
        ws  = '{32'hFFF00093, 32'hFE20AE23, 32'hFE000CE3, 32'h123452B7, 32'h000F8073, 32'h00509093};
        ss  = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
        e32 = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000, 32'h0000001F, 32'h00000005};
        e64 = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFF8,
                64'h0000000012345000, 64'h000000000000001F, 64'h0000000000000005};
        tick(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, ss[i], ws[i], 32'h100 + i, 1'b1, 1'b0, 1'b0);
            checks++; if (ov32 !== 1'b1 || tag32 !== 32'h100 + i) begin errors++; $display("[TB] FAIL fmt32[%0d] valid/tag: got %b/%h expected 1/%h", i, ov32, tag32, 32'h100 + i); end
            checks++; if (imm32 !== e32[i]) begin errors++; $display("[TB] FAIL fmt32[%0d] imm32: got %h expected %h", i, imm32, e32[i]); end
            checks++; if (imm64 !== e64[i]) begin errors++; $display("[TB] FAIL fmt32[%0d] imm64: got %h expected %h", i, imm64, e64[i]); end
        end
        tick(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        checks++; if (ov32 !== 1'b0 || imm32 !== 32'h0) begin errors++; $display("[TB] FAIL fmt32 drain: got %b/%h expected 0/0", ov32, imm32); end
    endtask

    task automatic test_formats64();
        logic [31:0] ws  [3];
        logic [2:0]  ss  [3];
        logic [31:0] e32 [3];
        logic [63:0] e64 [3];
        ws  = '{32'h800002B7, 32'h03F00093, 32'hFFFA8073};
        ss  = '{3'd4, 3'd6, 3'd5};
        e32 = '{32'h80000000, 32'h0000001F, 32'h00000015};
        e64 = '{64'hFFFFFFFF80000000, 64'h000000000000003F, 64'h0000000000000015};
        tick(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, ss[i], ws[i], 32'h200 + i, 1'b1, 1'b0, 1'b0);
            checks++; if (ov64 !== 1'b1 || tag64 !== 32'h200 + i) begin errors++; $display("[TB] FAIL fmt64[%0d] valid/tag: got %b/%h expected 1/%h", i, ov64, tag64, 32'h200 + i); end
            checks++; if (imm64 !== e64[i]) begin errors++; $display("[TB] FAIL fmt64[%0d] imm64: got %h expected %h", i, imm64, e64[i]); end
            checks++; if (imm32 !== e32[i]) begin errors++; $display("[TB] FAIL fmt64[%0d] imm32: got %h expected %h", i, imm32, e32[i]); end
        end
        tick(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        tick(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        tick(1'b1, 3'd0, 32'h00100093, 32'hAAAA, 1'b0, 1'b0, 1'b0);
        checks++; if (ov32 !== 1'b1 || tag32 !== 32'hAAAA || rdy32 !== 1'b1) begin errors++; $display("[TB] FAIL bp A: got v%b tag %h rdy %b expected v1 tag aaaa rdy 1", ov32, tag32, rdy32); end
        tick(1'b1, 3'd0, 32'h00200093, 32'hBBBB, 1'b0, 1'b0, 1'b0);
        checks++; if (rdy32 !== 1'b0 || rdy64 !== 1'b0) begin errors++; $display("[TB] FAIL bp ready after B: got %b/%b expected 0/0", rdy32, rdy64); end
        checks++; if (tag32 !== 32'hAAAA || imm32 !== 32'h1) begin errors++; $display("[TB] FAIL bp A held: got tag %h imm %h expected aaaa/1", tag32, imm32); end
        tick(1'b1, 3'd0, 32'h00300093, 32'hCCCC, 1'b0, 1'b0, 1'b0);
        checks++; if (tag32 !== 32'hAAAA || rdy32 !== 1'b0) begin errors++; $display("[TB] FAIL bp C refused: got tag %h rdy %b expected aaaa/0", tag32, rdy32); end
        tick(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        checks++; if (ov32 !== 1'b1 || tag32 !== 32'hBBBB || imm32 !== 32'h2) begin errors++; $display("[TB] FAIL bp B next: got v%b tag %h imm %h expected v1 bbbb 2", ov32, tag32, imm32); end
        checks++; if (rdy32 !== 1'b1 || rdy64 !== 1'b1) begin errors++; $display("[TB] FAIL bp ready back: got %b/%b expected 1/1", rdy32, rdy64); end
        tick(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        checks++; if (ov32 !== 1'b0 || ov64 !== 1'b0 || tag32 !== 32'h0) begin errors++; $display("[TB] FAIL bp drained (no C): got v%b/%b tag %h expected 0/0 0", ov32, ov64, tag32); end
    endtask

    task automatic test_illegal();
        tick(1'b1, 3'b111, 32'hFFFFFFFF, 32'h7777, 1'b1, 1'b0, 1'b0);
        checks++; if (imm32 !== 32'h0 || imm64 !== 64'h0) begin errors++; $display("[TB] FAIL illegal imm: got %h/%h expected 0", imm32, imm64); end
        checks++; if (ill32 !== 1'b1 || ill64 !== 1'b1 || ov32 !== 1'b1) begin errors++; $display("[TB] FAIL illegal flag: got %b/%b v%b expected 1/1 v1", ill32, ill64, ov32); end
        tick(1'b1, 3'd0, 32'h7FF00093, 32'h8888, 1'b1, 1'b0, 1'b0);
        checks++; if (ill32 !== 1'b0 || ill64 !== 1'b0 || imm32 !== 32'h000007FF) begin errors++; $display("[TB] FAIL illegal then I: got ill %b/%b imm %h expected 0/0 7ff", ill32, ill64, imm32); end
        tick(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_flush();
        tick(1'b1, 3'd0, 32'h00100093, 32'h1111, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 3'd0, 32'h00200093, 32'h2222, 1'b0, 1'b0, 1'b0);
        checks++; if (rdy32 !== 1'b0) begin errors++; $display("[TB] FAIL flush prefill ready: got %b expected 0", rdy32); end
        tick(1'b1, 3'd0, 32'h00300093, 32'h3333, 1'b0, 1'b1, 1'b0);
        checks++; if (ov32 !== 1'b0 || ov64 !== 1'b0 || rdy32 !== 1'b1 || rdy64 !== 1'b1) begin errors++; $display("[TB] FAIL flush: got v%b/%b rdy %b/%b expected 0/0 1/1", ov32, ov64, rdy32, rdy64); end
        tick(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        checks++; if (ov32 !== 1'b0 || tag32 !== 32'h0) begin errors++; $display("[TB] FAIL flush dropped: got v%b tag %h expected 0/0", ov32, tag32); end
    endtask

    task automatic test_reset_midstall();
        tick(1'b1, 3'd1, 32'hFE20AE23, 32'h4444, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 3'd1, 32'hFE20AE23, 32'h5555, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 3'd0, 32'hFFFFFFFF, 32'h6666, 1'b0, 1'b1, 1'b1);
        checks++; if (ov32 !== 1'b0 || ov64 !== 1'b0 || rdy32 !== 1'b1 || rdy64 !== 1'b1) begin errors++; $display("[TB] FAIL rst stall: got v%b/%b rdy %b/%b expected 0/0 1/1", ov32, ov64, rdy32, rdy64); end
        checks++; if (imm32 !== 32'h0 || imm64 !== 64'h0 || tag32 !== 32'h0 || ill32 !== 1'b0) begin errors++; $display("[TB] FAIL rst stall zero: got %h/%h tag %h ill %b expected 0", imm32, imm64, tag32, ill32); end
        tick(1'b1, 3'd3, 32'h0040006F, 32'h9999, 1'b1, 1'b0, 1'b0);
        checks++; if (ov32 !== 1'b1 || tag32 !== 32'h9999 || imm32 !== 32'h4 || imm64 !== 64'h4) begin errors++; $display("[TB] FAIL rst then J: got v%b tag %h imm %h/%h expected v1 9999 4/4", ov32, tag32, imm32, imm64); end
        tick(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] w, t;
        logic [2:0]  s;
        logic        v, r, f, rs;
        for (int n = 0; n < 600; n++) begin
            w  = $urandom;
            t  = $urandom;
            s  = 3'($urandom_range(0, 7));
            v  = ($urandom_range(0, 3) != 0);
            r  = ($urandom_range(0, 9) < 6);
            f  = ($urandom_range(0, 39) == 0);
            rs = ($urandom_range(0, 99) == 0);
            tick(v, s, w, t, r, f, rs);
            checks++; if (rdy32 !== (q.size() < 2) || rdy64 !== (q.size() < 2)) begin errors++; $display("[TB] FAIL rand[%0d] ready: got %b/%b expected %b", n, rdy32, rdy64, q.size() < 2); end
            checks++; if (ov32 !== (q.size() > 0) || ov64 !== (q.size() > 0)) begin errors++; $display("[TB] FAIL rand[%0d] valid: got %b/%b expected %b", n, ov32, ov64, q.size() > 0); end
            if (q.size() > 0) begin
                checks++; if (imm32 !== q[0].e32) begin errors++; $display("[TB] FAIL rand[%0d] imm32: got %h expected %h", n, imm32, q[0].e32); end
                checks++; if (imm64 !== q[0].e64) begin errors++; $display("[TB] FAIL rand[%0d] imm64: got %h expected %h", n, imm64, q[0].e64); end
                checks++; if (tag32 !== q[0].tag || tag64 !== q[0].tag) begin errors++; $display("[TB] FAIL rand[%0d] tag: got %h/%h expected %h", n, tag32, tag64, q[0].tag); end
                checks++; if (ill32 !== q[0].ill || ill64 !== q[0].ill) begin errors++; $display("[TB] FAIL rand[%0d] illegal: got %b/%b expected %b", n, ill32, ill64, q[0].ill); end
            end else begin
                checks++; if (imm32 !== 32'h0 || imm64 !== 64'h0 || tag32 !== 32'h0 || ill64 !== 1'b0) begin errors++; $display("[TB] FAIL rand[%0d] idle zero: got %h/%h tag %h ill %b expected 0", n, imm32, imm64, tag32, ill64); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_formats32();
        test_formats64();
        test_backpressure();
        test_illegal();
        test_flush();
        test_reset_midstall();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Pipelined, parametrised successor of the decode-stage immediate generator.
- Accepts instruction bits plus a format select and a sideband tag, and produces the XLEN-wide extended immediate one cycle later.
- Uses a valid/ready handshake and a 2-entry skid buffer so the decode→execute boundary can stall without combinational ready paths.
- Adds RV64 support, CSR zero-extended (Z) and shift-amount (SHAMT) formats, an illegal-select flag, and flush.

Parameters:
- XLEN, 32, output immediate width. Legal values are 32 or 64; any other value is an elaboration error.
- TAG_W, 32, sideband width (typically PC) carried alongside the immediate, unmodified.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_flush  in  1  synchronous pipeline flush.
- i_valid  in  1  upstream has a valid instruction.
- o_ready  out  1  block can accept; registered.
- i_inst  in  25  instruction bits [31:7]; internal index equals the ISA bit index.
- i_imm_sel  in  3  format: 000 I, 001 S, 010 B, 011 J, 100 U, 101 Z, 110 SHAMT, 111 reserved.
- i_tag  in  TAG_W  sideband.
- o_valid  out  1  output entry valid.
- i_ready  in  1  downstream accepts.
- o_imm  out  XLEN  extended immediate.
- o_tag  out  TAG_W  sideband of the output entry.
- o_illegal  out  1  entry had a reserved select.

Behaviour:
- Formats (s = inst[31], replicated to XLEN):
  - I: {s.., inst[31:20]}.
  - S: {s.., inst[31:25], inst[11:7]}.
  - B: {s.., inst[7], inst[30:25], inst[11:8], 0}.
  - J: {s.., inst[19:12], inst[20], inst[30:21], 0}.
  - U: {s.. (XLEN-32 bits), inst[31:12], 12'b0}. XLEN=32 has no extension; XLEN=64 sign-extends per RV64 LUI/AUIPC.
  - Z: zero-extend inst[19:15].
  - SHAMT: zero-extend inst[24:20] if XLEN=32, inst[25:20] if XLEN=64.
  - 111: o_imm = 0 and o_illegal = 1. o_illegal = 0 for every other select.
- Handshakes: accept = i_valid & o_ready; emit = o_valid & i_ready.
- Storage: main output register (M) plus skid register (K). Each holds {imm, tag, illegal, valid}.
- Latency: immediate computed combinationally and captured on accept; it appears on o_imm/o_tag the cycle after accept. Throughput is 1/cycle when i_ready stays 1.
- Transitions, priority top-down:
  - M empty or emitted this cycle, K empty: accepted data goes to M.
  - M full and not emitted, K empty: accepted data goes to K; o_ready falls next cycle.
  - M emitted and K full: K moves to M, K clears, o_ready rises next cycle. No accept is possible, since o_ready was 0.
  - Accept and emit in the same cycle with K empty: M is replaced; no bubble.
- o_ready = ~K.valid, registered. It never depends combinationally on i_ready or i_valid.
- Outputs are held stable while o_valid=1 and i_ready=0. o_imm/o_tag/o_illegal are don't-care when o_valid=0, but the implementation drives 0.
- Flush: when i_flush=1, M.valid and K.valid clear at the edge. Any accept in the same cycle is dropped. o_ready=1 next cycle. Flush has priority over all transitions.
- Reset: when i_rst=1 (dominant over flush), at the edge o_valid=0, K empty, o_ready=1, and o_imm/o_tag/o_illegal=0. Reset mid-stall discards both entries.
- No X propagation: a reserved select never produces X.

Test Plan:
- XLEN=32, i_ready=1, the following back-to-back → each appears one cycle later, in order, no bubbles:
  - I 0xFFF00093 → 0xFFFFFFFF.
  - S 0xFE20AE23 → 0xFFFFFFFC.
  - B 0xFE000CE3 → 0xFFFFFFF8.
  - U 0x123452B7 → 0x12345000.
  - Z with inst[19:15]=11111 → 0x0000001F.
  - SHAMT for 0x00509093 → 0x00000005.
- XLEN=64:
  - U 0x800002B7 → 0xFFFFFFFF80000000.
  - SHAMT with inst[25:20]=0x3F → 0x3F.
  - Z → upper 59 bits 0.
- Backpressure: i_ready=0, accept tags A and B.
  - After B: o_ready=0 next cycle; o_tag=A stable; a third request is not accepted.
  - Raise i_ready: A, then B, emitted on consecutive cycles; o_ready returns to 1 one cycle after K drains.
- i_imm_sel=111, inst 0xFFFFFFFF → o_imm=0, o_illegal=1. The next valid I-type → o_illegal=0.
- With M and K full, assert i_flush together with i_valid → o_valid=0 next cycle, o_ready=1, the flushed-cycle instruction is never emitted.
- Assert i_rst mid-stall with K full → next cycle o_valid=0, o_ready=1, all outputs 0. A subsequent accept behaves normally with 1-cycle latency.
